// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and byte width.
// Imported by the arbiter top.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [4:0] {
        S_ARB       = 5'b00001,
        S_FETCH     = 5'b00010,
        S_LAUNCH    = 5'b00100,
        S_WAIT_BUSY = 5'b01000,
        S_WAIT_DONE = 5'b10000
    } state_e;

    // Counter width able to hold n; never zero bits.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant of the first
// requester at or after the pointer, wrapping modulo N.
module uart_tx_arbiter_rr #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW-1:0] idx;

    // Walk offsets high to low so the nearest requester wins last.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx between byte
// sources; sequences the serializer through its rdy/busy handshake.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int HOLD_TIMEOUT = 1023,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_SRC-1:0]        i_req_valid,
    input  logic [BYTE_W*NUM_SRC-1:0] i_req_data,
    input  logic [NUM_SRC-1:0]        i_req_last,
    output logic [NUM_SRC-1:0]        o_req_ready,
    output logic [NUM_SRC-1:0]        o_grant,
    output logic                      o_tx_byte_rdy,
    output logic [BYTE_W-1:0]         o_tx_byte,
    input  logic                      i_tx_busy,
    output logic                      o_err
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int HW = cnt_w(HOLD_TIMEOUT);
    localparam int BW = cnt_w(BUSY_TIMEOUT);

    state_e              state_q;
    logic [PW-1:0]       ptr_q;
    logic [HW-1:0]       hold_q;
    logic [BW-1:0]       busy_q;
    logic                last_q;
    logic [NUM_SRC-1:0]  grant_q;
    logic [BYTE_W-1:0]   byte_q;
    logic                rdy_q;
    logic                err_q;

    logic [NUM_SRC-1:0]  pick;
    logic [PW-1:0]       gidx;
    logic [PW-1:0]       gnext;
    logic                g_valid;
    logic                g_last;
    logic [BYTE_W-1:0]   g_data;

    uart_tx_arbiter_rr #(.N(NUM_SRC)) u_rr (
        .req_i (i_req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        gidx   = '0;
        g_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_q[s]) begin
                gidx   = PW'(s);
                g_data = i_req_data[BYTE_W*s +: BYTE_W];
            end
        end
    end

    assign gnext   = (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
    assign g_valid = |(i_req_valid & grant_q);
    assign g_last  = |(i_req_last & grant_q);

    assign o_req_ready   = (state_q == S_FETCH) ? (i_req_valid & grant_q) : '0;
    assign o_grant       = grant_q;
    assign o_tx_byte_rdy = rdy_q;
    assign o_tx_byte     = byte_q;
    assign o_err         = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_ARB;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            byte_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                S_ARB: begin
                    // uart_tx is not reset with us; let a stale byte drain.
                    if (!i_tx_busy && |pick) begin
                        grant_q <= pick;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (g_valid) begin
                        byte_q  <= g_data;
                        last_q  <= g_last;
                        hold_q  <= '0;
                        rdy_q   <= 1'b1;
                        state_q <= S_LAUNCH;
                    end else if (HOLD_TIMEOUT != 0) begin
                        if (hold_q == HW'(HOLD_TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            hold_q  <= '0;
                            grant_q <= '0;
                            ptr_q   <= gnext;
                            state_q <= S_ARB;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    busy_q  <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (busy_q == BW'(BUSY_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        ptr_q   <= gnext;
                        state_q <= S_ARB;
                    end else begin
                        busy_q <= busy_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= gnext;
                            state_q <= S_ARB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx
// (4 clocks per bit, no reset) and queue-driven byte sources.
module tb_uart_tx_arbiter;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   vld;
    logic [8*NS-1:0] data;
    logic [NS-1:0]   last;
    logic [NS-1:0]   rdy;
    logic [NS-1:0]   grant;
    logic            tx_rdy;
    logic [7:0]      tx_byte;
    logic            tx_busy;
    logic            err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_SRC      (NS),
        .HOLD_TIMEOUT (8),
        .BUSY_TIMEOUT (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (vld),
        .i_req_data    (data),
        .i_req_last    (last),
        .o_req_ready   (rdy),
        .o_grant       (grant),
        .o_tx_byte_rdy (tx_rdy),
        .o_tx_byte     (tx_byte),
        .i_tx_busy     (tx_busy),
        .o_err         (err)
    );

    typedef struct {
        int         src;
        logic [7:0] b;
    } launch_t;

    typedef struct {
        logic [NS-1:0] vld;
        int            exp;
    } rr_vec_t;

    int          checks = 0;
    int          errors = 0;
    int          leak_cnt = 0;
    int          busy_launch = 0;
    launch_t     log_q[$];
    logic [9:0]  rx_q[$];
    logic [8:0]  srcq[NS][$];
    logic        uart_stub;
    int          ucnt;
    logic [9:0]  frame;
    logic [9:0]  rx_sh;
    logic        line;
    logic [NS-1:0] take;
    logic        launch;
    logic [7:0]  lb;

    function automatic int oh2i(input logic [NS-1:0] v);
        int r = -1;
        for (int i = 0; i < NS; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_src();
        for (int s = 0; s < NS; s++) begin
            if (srcq[s].size() > 0) begin
                vld[s]         = 1'b1;
                data[8*s +: 8] = srcq[s][0][7:0];
                last[s]        = srcq[s][0][8];
            end else begin
                vld[s]         = 1'b0;
                data[8*s +: 8] = 8'h00;
                last[s]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic l);
        srcq[s].push_back({l, b});
    endtask

    // Sources, launch monitor and uart_tx model share one process.
    initial begin
        forever begin
            @(negedge clk);
            take   = vld & rdy;
            launch = tx_rdy;
            lb     = tx_byte;
            if ((rdy & ~grant) != '0) leak_cnt++;
            if (launch) begin
                if (tx_busy) busy_launch++;
                log_q.push_back('{src: oh2i(grant), b: lb});
            end
            if (tx_busy && ucnt[1:0] == 2'd2) begin
                rx_sh = {line, rx_sh[9:1]};
                if (ucnt == 38) rx_q.push_back(rx_sh);
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++)
                if (take[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
            drive_src();
            if (uart_stub) begin
                tx_busy = 1'b0;
            end else if (tx_busy) begin
                if (ucnt == 39) tx_busy = 1'b0;
                else ucnt++;
            end else if (launch) begin
                frame   = {1'b1, lb, 1'b0};
                ucnt    = 0;
                tx_busy = 1'b1;
            end
            line = tx_busy ? frame[4'(ucnt / 4)] : 1'b1;
        end
    end

    task automatic wait_launch(input string nm, output launch_t l);
        int n = 0;
        while (log_q.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (log_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no launch within 200 cycles", nm);
            l = '{src: -1, b: 8'h00};
        end else begin
            l = log_q.pop_front();
        end
    endtask

    task automatic wait_busy(input string nm, input logic lvl);
        int n = 0;
        @(negedge clk);
        while (tx_busy !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: busy not %0b within 200 cycles", nm, lvl);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while ((grant != '0 || tx_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (grant != '0 || tx_busy) begin
            checks++;
            errors++;
            $display("FAIL %s: not idle within 300 cycles", nm);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [9:0] pop_rx();
        if (rx_q.size() == 0) return 'x;
        return rx_q.pop_back();
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_vec_t tbl[8];
        launch_t l;
        int      exp_src[6];
        logic [7:0] exp_b[6];
        int      n;

        tbl[0] = '{vld: 4'b1001, exp: 0};
        tbl[1] = '{vld: 4'b1101, exp: 2};
        tbl[2] = '{vld: 4'b0110, exp: 1};
        tbl[3] = '{vld: 4'b0011, exp: 0};
        tbl[4] = '{vld: 4'b0010, exp: 1};
        tbl[5] = '{vld: 4'b1000, exp: 3};
        tbl[6] = '{vld: 4'b1110, exp: 1};
        tbl[7] = '{vld: 4'b1111, exp: 2};
        exp_src = '{0, 0, 1, 1, 2, 2};
        exp_b   = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};

        rst       = 1'b1;
        uart_stub = 1'b0;
        tx_busy   = 1'b0;
        ucnt      = 0;
        frame     = '1;
        rx_sh     = '0;
        line      = 1'b1;
        drive_src();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(rdy), 0);
        chk("rst_tx_rdy", 32'(tx_rdy), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_err", 32'(err), 0);

        // single-byte packet, serial frame check
        push(0, 8'h55, 1'b1);
        wait_launch("t1_launch", l);
        chk("t1_src", l.src, 0);
        chk("t1_byte", 32'(l.b), 32'h55);
        @(negedge clk);
        chk("t1_grant_held", 32'(grant), 32'b0001);
        wait_idle("t1_idle");
        chk("t1_grant_rel", 32'(grant), 0);
        chk("t1_err", 32'(err), 0);
        chk("t1_frame", 32'(pop_rx()), 32'b1010101010);

        // three 2-byte packets at once: no interleave
        pulse_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wait_launch("t2_launch", l);
            chk($sformatf("t2_src%0d", i), l.src, exp_src[i]);
            chk($sformatf("t2_byte%0d", i), 32'(l.b), 32'(exp_b[i]));
        end
        wait_idle("t2_idle");

        // pointer at 3: src3 before src0, then wrap favours src0
        push(0, 8'hD0, 1'b1);
        push(3, 8'hE3, 1'b1);
        push(3, 8'hE4, 1'b1);
        wait_launch("t3_l0", l);
        chk("t3_src0", l.src, 3);
        chk("t3_byte0", 32'(l.b), 32'hE3);
        wait_launch("t3_l1", l);
        chk("t3_src1", l.src, 0);
        chk("t3_byte1", 32'(l.b), 32'hD0);
        wait_launch("t3_l2", l);
        chk("t3_src2", l.src, 3);
        chk("t3_byte2", 32'(l.b), 32'hE4);
        wait_idle("t3_idle");

        // round-robin table, pointer starts at 0
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < NS; s++)
                if (tbl[i].vld[s]) push(s, 8'(s * 16 + i), 1'b1);
            wait_launch("rr_launch", l);
            chk($sformatf("rr%0d_src", i), l.src, tbl[i].exp);
            chk($sformatf("rr%0d_byte", i), 32'(l.b),
                32'(tbl[i].exp * 16 + i));
            for (int s = 0; s < NS; s++)
                if (s != tbl[i].exp) srcq[s].delete();
            wait_idle("rr_idle");
        end

        // hold timeout: src1 stalls after one byte
        pulse_reset();
        push(1, 8'hF0, 1'b0);
        push(2, 8'hC2, 1'b1);
        wait_launch("t4_launch", l);
        chk("t4_src", l.src, 1);
        chk("t4_byte", 32'(l.b), 32'hF0);
        wait_busy("t4_rise", 1'b1);
        wait_busy("t4_fall", 1'b0);
        repeat (8) @(negedge clk);
        chk("t4_err_pre", 32'(err), 0);
        chk("t4_grant_pre", 32'(grant), 32'b0010);
        @(negedge clk);
        chk("t4_err", 32'(err), 1);
        chk("t4_grant_rel", 32'(grant), 0);
        wait_launch("t4_next", l);
        chk("t4_next_src", l.src, 2);
        chk("t4_next_byte", 32'(l.b), 32'hC2);
        wait_idle("t4_idle");
        chk("t4_err_sticky", 32'(err), 1);

        // busy never rises
        pulse_reset();
        chk("t5_err_clr", 32'(err), 0);
        uart_stub = 1'b1;
        push(0, 8'h3C, 1'b1);
        n = 0;
        @(negedge clk);
        while (!tx_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_launch_seen", 32'(tx_rdy), 1);
        repeat (3) @(negedge clk);
        chk("t5_err_early", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("t5_err", 32'(err), 1);
        chk("t5_grant", 32'(grant), 0);
        chk("t5_ready", 32'(rdy), 0);
        wait_launch("t5_log", l);
        chk("t5_byte", 32'(l.b), 32'h3C);
        uart_stub = 1'b0;

        // reset during data bit 3
        pulse_reset();
        rx_q.delete();
        push(0, 8'h96, 1'b1);
        wait_launch("t6_launch", l);
        chk("t6_src", l.src, 0);
        n = 0;
        while (!(tx_busy && ucnt == 17) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_mid_byte", 32'(ucnt), 17);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_ready", 32'(rdy), 0);
        chk("t6_rst_tx_rdy", 32'(tx_rdy), 0);
        chk("t6_rst_byte", 32'(tx_byte), 0);
        chk("t6_rst_err", 32'(err), 0);
        rst = 1'b0;
        push(1, 8'h5A, 1'b1);
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_relaunch_lat", n, 2);
        wait_launch("t6_next", l);
        chk("t6_next_src", l.src, 1);
        chk("t6_next_byte", 32'(l.b), 32'h5A);
        wait_idle("t6_idle");
        chk("t6_frame", 32'(pop_rx()), 32'({1'b1, 8'h5A, 1'b0}));

        chk("ready_leak", leak_cnt, 0);
        chk("launch_while_busy", busy_launch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
